// File: rtl/telemetry_frame_parser_pkg.sv
// telemetry_frame_parser_pkg: shared state encoding, frame geometry and field byte offsets.
package telemetry_pkg;
  typedef enum logic [1:0] {IDLE, PAYLOAD, CHKSUM} state_e;
  localparam int PAYLOAD_BYTES = 8;
  localparam int FRAME_BYTES = 10;
  localparam logic [7:0] SYNC_BYTE_DEF = 8'hA5;
  localparam int FREQ_HI = 0;
  localparam int DISK_HI = 2;
  localparam int MEM_HI = 4;
  localparam int TEMP_HI = 6;
endpackage

// File: rtl/telemetry_frame_parser_if.sv
// telemetry_frame_parser_if: UART byte input and decoded telemetry outputs.
interface telemetry_frame_parser_if #(parameter int ERR_CNT_W = 8) ();
  logic [7:0] rx_data;
  logic rx_valid;
  logic [15:0] cpu_freq_mhz;
  logic [15:0] disk_speed_mbps;
  logic [15:0] memory_usage;
  logic [15:0] temperature_c;
  logic frame_valid;
  logic chk_err;
  logic timeout_err;
  logic [ERR_CNT_W-1:0] chk_err_count;
  logic busy;
  modport master (
    output rx_data, rx_valid,
    input cpu_freq_mhz, disk_speed_mbps, memory_usage, temperature_c,
    input frame_valid, chk_err, timeout_err, chk_err_count, busy
  );
  modport slave (
    input rx_data, rx_valid,
    output cpu_freq_mhz, disk_speed_mbps, memory_usage, temperature_c,
    output frame_valid, chk_err, timeout_err, chk_err_count, busy
  );
endinterface

// File: rtl/telemetry_frame_parser_timeout_ctr.sv
// frame_timeout_ctr: idle-cycle counter, cleared when disabled or on clr_i, flags the final idle cycle.
module frame_timeout_ctr #(
  parameter int TIMEOUT_CYCLES = 100000
) (
  input  logic clk,
  input  logic rst,
  input  logic en_i,
  input  logic clr_i,
  output logic tc_o
);
  localparam int W = $clog2(TIMEOUT_CYCLES + 1);
  logic [W-1:0] cnt_q, cnt_d;
  always_comb cnt_d = (clr_i || !en_i) ? '0 : cnt_q + 1'b1;
  always_ff @(posedge clk or posedge rst)
    if (rst) cnt_q <= '0;
    else cnt_q <= cnt_d;
  assign tc_o = en_i && !clr_i && (cnt_q == W'(TIMEOUT_CYCLES - 1));
endmodule

// File: rtl/telemetry_frame_parser.sv
// telemetry_frame_parser: assembles checksummed 10-byte UART frames into four registered 16-bit metrics.
module telemetry_frame_parser
  import telemetry_pkg::*;
#(
  parameter logic [7:0] SYNC_BYTE = SYNC_BYTE_DEF,
  parameter int TIMEOUT_CYCLES = 100000,
  parameter int ERR_CNT_W = 8
) (
  input logic clk,
  input logic rst,
  telemetry_frame_parser_if.slave bus
);
  state_e state_q, state_d;
  logic [2:0] idx_q, idx_d;
  logic [7:0] sum_q, sum_d, total;
  logic [PAYLOAD_BYTES-1:0][7:0] shadow_q, shadow_d, fields_q, fields_d;
  logic fv_q, fv_d, ce_q, ce_d, te_q, te_d, tc;
  logic [ERR_CNT_W-1:0] cnt_q, cnt_d;
  assign total = sum_q + bus.rx_data;
  frame_timeout_ctr #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_timeout (
    .clk,
    .rst,
    .en_i (state_q != IDLE),
    .clr_i(bus.rx_valid),
    .tc_o (tc)
  );
  always_comb begin
    state_d = state_q;
    idx_d = idx_q;
    sum_d = sum_q;
    shadow_d = shadow_q;
    fields_d = fields_q;
    cnt_d = cnt_q;
    fv_d = 1'b0;
    ce_d = 1'b0;
    te_d = 1'b0;
    unique case (state_q)
      IDLE:
        if (bus.rx_valid && bus.rx_data == SYNC_BYTE) begin
          state_d = PAYLOAD;
          idx_d = '0;
          sum_d = '0;
        end
      PAYLOAD:
        if (bus.rx_valid) begin
          shadow_d[idx_q] = bus.rx_data;
          sum_d = total;
          idx_d = idx_q + 3'd1;
          state_d = (idx_q == 3'(PAYLOAD_BYTES - 1)) ? CHKSUM : PAYLOAD;
        end else if (tc) begin
          state_d = IDLE;
          te_d = 1'b1;
        end
      CHKSUM:
        if (bus.rx_valid) begin
          state_d = IDLE;
          fv_d = (total == 8'd0);
          ce_d = (total != 8'd0);
          fields_d = fv_d ? shadow_q : fields_q;
          cnt_d = (ce_d && !(&cnt_q)) ? cnt_q + 1'b1 : cnt_q;
        end else if (tc) begin
          state_d = IDLE;
          te_d = 1'b1;
        end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state_q <= IDLE;
      idx_q <= '0;
      sum_q <= '0;
      shadow_q <= '0;
      fields_q <= '0;
      cnt_q <= '0;
      fv_q <= 1'b0;
      ce_q <= 1'b0;
      te_q <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q <= idx_d;
      sum_q <= sum_d;
      shadow_q <= shadow_d;
      fields_q <= fields_d;
      cnt_q <= cnt_d;
      fv_q <= fv_d;
      ce_q <= ce_d;
      te_q <= te_d;
    end
  assign bus.cpu_freq_mhz = {fields_q[FREQ_HI], fields_q[FREQ_HI+1]};
  assign bus.disk_speed_mbps = {fields_q[DISK_HI], fields_q[DISK_HI+1]};
  assign bus.memory_usage = {fields_q[MEM_HI], fields_q[MEM_HI+1]};
  assign bus.temperature_c = {fields_q[TEMP_HI], fields_q[TEMP_HI+1]};
  assign bus.frame_valid = fv_q;
  assign bus.chk_err = ce_q;
  assign bus.timeout_err = te_q;
  assign bus.chk_err_count = cnt_q;
  assign bus.busy = (state_q != IDLE);
endmodule

// File: doc/telemetry_frame_parser.md
Name: telemetry_frame_parser

Overview:
Receives the UART RX byte stream from the telemetry link and assembles fixed-length frames of four 16-bit metrics. It validates each frame with a checksum and presents the metrics as stable registered fields. On every good frame it emits a one-cycle frame_valid pulse, which drives compute_enable of the downstream scoring stage. Malformed or stalled frames are dropped and counted.

Parameters:
SYNC_BYTE, 8'hA5, frame start marker.
TIMEOUT_CYCLES, 100000, maximum idle clk cycles allowed between bytes inside a frame.
ERR_CNT_W, 8, width of the saturating checksum-error counter.

Ports:
clk  in  1  system clock.
rst  in  1  asynchronous, active-high reset.
rx_data  in  8  received byte from the UART RX.
rx_valid  in  1  one-cycle strobe; rx_data is valid this cycle.
cpu_freq_mhz  out  16  last good-frame CPU frequency.
disk_speed_mbps  out  16  last good-frame disk speed.
memory_usage  out  16  last good-frame memory usage.
temperature_c  out  16  last good-frame temperature.
frame_valid  out  1  one-cycle pulse: fields were updated from a good frame.
chk_err  out  1  one-cycle pulse: checksum mismatch.
timeout_err  out  1  one-cycle pulse: inter-byte timeout.
chk_err_count  out  ERR_CNT_W  saturating count of checksum errors.
busy  out  1  high while state != IDLE.

Behaviour:
- Reset: all outputs 0, state IDLE, shadow registers and timeout counter cleared. A reset mid-frame discards the partial frame; it produces no error pulse and no count.
- Frame format, 10 bytes: SYNC_BYTE, then 8 payload bytes, then 1 checksum byte.
- Payload order is big-endian: freq[15:8], freq[7:0], disk[15:8], disk[7:0], mem[15:8], mem[7:0], temp[15:8], temp[7:0].
- Checksum rule: (sum of 8 payload bytes + checksum byte) mod 256 == 0.
- States:
  - IDLE: on rx_valid with rx_data==SYNC_BYTE, go to PAYLOAD with idx=0 and running sum=0. Other bytes are discarded silently.
  - PAYLOAD: on each rx_valid, store the byte into the shadow register at idx, add it to the 8-bit running sum, and increment idx. After the byte at idx=7, go to CHKSUM. A byte equal to SYNC_BYTE is treated as data; there is no resync.
  - CHKSUM: on rx_valid, compare (sum + rx_data) mod 256 to 0.
    - Match: copy the shadow registers to the output fields and pulse frame_valid.
    - Mismatch: pulse chk_err and increment chk_err_count, saturating at all-ones.
    - In both cases return to IDLE.
- Latency: frame_valid and the updated fields appear on the cycle after the checksum byte's rx_valid edge. Fields are registered and stay stable until the next good frame. They are never modified by bad or partial frames.
- Timeout counter:
  - Runs only in PAYLOAD and CHKSUM.
  - Clears on entry to those states and on every rx_valid.
  - When it reaches TIMEOUT_CYCLES-1 with no rx_valid, the parser goes to IDLE and pulses timeout_err.
- Simultaneous events:
  - rx_valid in the same cycle the timeout would fire: the byte wins, it is processed normally, and there is no timeout.
  - A SYNC_BYTE received as the checksum byte ends the frame; it does not start a new one.
- Back-to-back frames: a SYNC_BYTE on the cycle immediately after the checksum byte is accepted.
- The byte rate is far below clk, so there is no back-pressure and no buffering.

Decomposition:
- telemetry_pkg:
  - state enum {IDLE, PAYLOAD, CHKSUM}.
  - PAYLOAD_BYTES=8.
  - FRAME_BYTES=10.
  - Default SYNC_BYTE constant.
  - Field byte-index constants.
- Sub-module frame_timeout_ctr: an inputs-are-clear/enable counter with a terminal-count pulse, parameterised by TIMEOUT_CYCLES.

Test Plan:
1. Good frame: bytes A5 07 D0 01 F4 10 00 00 2D F7 -> one frame_valid pulse the cycle after F7. Fields read 2000, 500, 4096, 45; chk_err_count stays 0.
2. Bad checksum: same frame with last byte F6 -> chk_err pulse, chk_err_count=1, no frame_valid, fields keep the previous values.
3. Timeout: A5 07 D0, then no bytes for TIMEOUT_CYCLES (set 16) -> timeout_err pulse and busy low. A following good frame is then decoded correctly.
4. Garbage and embedded sync:
   - Garbage: 3C 11 before A5 -> ignored.
   - Payload containing A5: A5 A5 A5 00 00 00 00 00 00 B6 -> frame_valid with freq=0xA5A5, others 0.
5. Saturation and reset:
   - Force 300 bad frames with ERR_CNT_W=8 -> chk_err_count holds 255.
   - Assert rst mid-payload -> all outputs 0, busy 0, no error pulses.
6. Edge race: the byte arrives exactly on the timeout cycle -> no timeout_err, and the frame completes with frame_valid.
